axi_burst_reader: RTL and testbench

Read-DMA engine inside the accelerator top that drives the 64-bit AXI3 master read port (MAXI0/MAXI1 read channels) of the Verilator SoC wrapper. Given a base address and byte length from the control registers, it issues fixed 16-beat INCR bursts, buffers returning beats in an internal FIFO, and presents them to the pipeline as a packed {valid,data} stream. Credit-based issue guarantees RREADY never blocks on a full buffer.

---
 rtl/axi_rd_pkg.sv | 15 +
 rtl/beat_fifo.sv | 87 ++++++++
 rtl/axi_burst_reader.sv | 174 +++++++++++++++++
 tb/tb_axi_burst_reader.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_rd_pkg.sv
// rtl/axi_rd_pkg.sv - shared constants and state type for the AXI3 read-DMA engine
package axi_rd_pkg;

  localparam int          BEAT_BYTES   = 8;
  localparam int          BURST_BYTES  = 128;
  localparam logic [1:0]  ARSIZE_8B    = 2'b11;
  localparam logic [1:0]  ARBURST_INCR = 2'b01;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } rd_state_t;

endpackage

// File: rtl/beat_fifo.sv
// rtl/beat_fifo.sv - beat buffer with registered first-word-fall-through head
// Ports: clk_i / rst_ni        clock, asynchronous active-low reset
//        push_i / push_data_i  write side, one beat per cycle
//        pop_i                 downstream accept of the head beat
//        out_valid_o/out_data_o registered head of the queue
//        count_o               beats held, head register included
module beat_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 32
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         push_data_i,
  input  logic                     pop_i,
  output logic                     out_valid_o,
  output logic [WIDTH-1:0]         out_data_o,
  output logic [$clog2(DEPTH)+1:0] count_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      mem_cnt_q;
  logic             out_valid_q;
  logic [WIDTH-1:0] out_data_q;

  logic load_out;
  logic mem_rd;
  logic mem_wr;
  logic bypass;

  // The head register refills whenever it is empty or being popped; an empty
  // backing store lets a fresh beat go straight to the head (one-cycle latency).
  always_comb begin
    load_out = !out_valid_q || pop_i;
    mem_rd   = load_out && (mem_cnt_q != '0);
    bypass   = load_out && (mem_cnt_q == '0) && push_i;
    mem_wr   = push_i && !bypass;
  end

  always_ff @(posedge clk_i) begin
    if (mem_wr) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      mem_cnt_q   <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      if (mem_wr) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      if (mem_rd) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      if (mem_wr && !mem_rd) begin
        mem_cnt_q <= mem_cnt_q + (AW+1)'(1);
      end else if (!mem_wr && mem_rd) begin
        mem_cnt_q <= mem_cnt_q - (AW+1)'(1);
      end
      if (load_out) begin
        if (mem_rd) begin
          out_valid_q <= 1'b1;
          out_data_q  <= mem_q[rd_ptr_q];
        end else if (bypass) begin
          out_valid_q <= 1'b1;
          out_data_q  <= push_data_i;
        end else begin
          out_valid_q <= 1'b0;
        end
      end
    end
  end

  assign out_valid_o = out_valid_q;
  assign out_data_o  = out_data_q;
  assign count_o     = {1'b0, mem_cnt_q} + {{(AW+1){1'b0}}, out_valid_q};

endmodule

// File: rtl/axi_burst_reader.sv
// rtl/axi_burst_reader.sv - credit-based AXI3 16-beat INCR read-DMA engine
// Ports: IP_CLK / IP_ARESET_N  clock, asynchronous active-low reset
//        start, base_addr, len_bytes  job request (128-byte granules)
//        busy, done, err              job status
//        M_AR*  read address channel; M_R* read data channel
//        out_data {valid,beat}, out_ready  buffered beat stream
module axi_burst_reader
  import axi_rd_pkg::*;
#(
  parameter int FIFO_DEPTH  = 32,
  parameter int BURST_BEATS = 16
) (
  input  logic        IP_CLK,
  input  logic        IP_ARESET_N,
  input  logic        start,
  input  logic [31:0] base_addr,
  input  logic [31:0] len_bytes,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [31:0] M_ARADDR,
  output logic        M_ARVALID,
  input  logic        M_ARREADY,
  output logic [3:0]  M_ARLEN,
  output logic [1:0]  M_ARSIZE,
  output logic [1:0]  M_ARBURST,
  input  logic [63:0] M_RDATA,
  input  logic        M_RVALID,
  output logic        M_RREADY,
  input  logic [1:0]  M_RRESP,
  input  logic        M_RLAST,
  output logic [64:0] out_data,
  input  logic        out_ready
);

  localparam int             CW           = $clog2(FIFO_DEPTH) + 2;
  localparam logic [CW-1:0]  BEATS_C      = CW'(BURST_BEATS);
  localparam logic [CW-1:0]  CREDIT_LIMIT = CW'(FIFO_DEPTH - BURST_BEATS);

  rd_state_t     state_q;
  logic [31:0]   addr_q;
  logic [24:0]   bursts_left_q;
  logic [24:0]   bursts_left_d;
  logic [CW-1:0] outstanding_q;
  logic [CW-1:0] outstanding_d;
  logic [CW-1:0] count_d;
  logic [CW-1:0] fifo_count;
  logic [3:0]    beat_cnt_q;
  logic          arvalid_q;
  logic          busy_q;
  logic          done_q;
  logic          err_q;

  logic          fifo_valid;
  logic [63:0]   fifo_data;
  logic          ar_hs;
  logic          r_hs;
  logic          pop;
  logic          credit_ok;
  logic          beat_err;
  logic          fifo_empty_next;
  logic          unused_low_bits;

  assign unused_low_bits = ^{base_addr[6:0], len_bytes[6:0]};

  assign M_RREADY = (state_q != IDLE);

  // Credit is judged on next-cycle occupancy so a registered ARVALID can
  // never reserve space that a burst issued this cycle already claimed.
  always_comb begin
    ar_hs         = arvalid_q && M_ARREADY;
    r_hs          = M_RVALID && M_RREADY;
    pop           = fifo_valid && out_ready;
    bursts_left_d = bursts_left_q - {24'd0, ar_hs};
    outstanding_d = outstanding_q;
    if (ar_hs) begin
      outstanding_d = outstanding_d + BEATS_C;
    end
    if (r_hs && (outstanding_q != '0)) begin
      outstanding_d = outstanding_d - CW'(1);
    end
    count_d         = fifo_count + CW'(r_hs) - CW'(pop);
    credit_ok       = (count_d + outstanding_d) <= CREDIT_LIMIT;
    beat_err        = (M_RRESP != 2'b00) || (M_RLAST != (beat_cnt_q == 4'hF));
    // done must land the cycle after the last pop, so look one pop ahead.
    fifo_empty_next = (fifo_count == '0) || ((fifo_count == CW'(1)) && pop);
  end

  always_ff @(posedge IP_CLK or negedge IP_ARESET_N) begin
    if (!IP_ARESET_N) begin
      state_q       <= IDLE;
      addr_q        <= '0;
      bursts_left_q <= '0;
      outstanding_q <= '0;
      beat_cnt_q    <= '0;
      arvalid_q     <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      done_q        <= 1'b0;
      outstanding_q <= outstanding_d;
      if (r_hs) begin
        beat_cnt_q <= beat_cnt_q + 4'd1;
        if (beat_err) begin
          err_q <= 1'b1;
        end
      end
      case (state_q)
        IDLE: begin
          if (start) begin
            addr_q        <= {base_addr[31:7], 7'b0};
            bursts_left_q <= len_bytes[31:7];
            err_q         <= 1'b0;
            beat_cnt_q    <= '0;
            if (len_bytes[31:7] == 25'd0) begin
              done_q <= 1'b1;
            end else begin
              state_q   <= RUN;
              busy_q    <= 1'b1;
              arvalid_q <= credit_ok;
            end
          end
        end
        RUN: begin
          if (ar_hs) begin
            addr_q        <= addr_q + 32'(BURST_BYTES);
            bursts_left_q <= bursts_left_d;
          end
          // A pending request is held until accepted.
          if (!arvalid_q || M_ARREADY) begin
            arvalid_q <= (bursts_left_d != 25'd0) && credit_ok;
          end
          if (ar_hs && (bursts_left_d == 25'd0)) begin
            state_q <= DRAIN;
          end
        end
        DRAIN: begin
          if ((outstanding_q == '0) && fifo_empty_next) begin
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  beat_fifo #(
    .WIDTH (64),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i       (IP_CLK),
    .rst_ni      (IP_ARESET_N),
    .push_i      (r_hs),
    .push_data_i (M_RDATA),
    .pop_i       (out_ready),
    .out_valid_o (fifo_valid),
    .out_data_o  (fifo_data),
    .count_o     (fifo_count)
  );

  assign M_ARADDR  = addr_q;
  assign M_ARVALID = arvalid_q;
  assign M_ARLEN   = 4'(BURST_BEATS - 1);
  assign M_ARSIZE  = ARSIZE_8B;
  assign M_ARBURST = ARBURST_INCR;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;
  assign out_data  = {fifo_valid, fifo_data};

endmodule

// File: tb/tb_axi_burst_reader.sv
// tb/tb_axi_burst_reader.sv - scoreboard bench for axi_burst_reader
module tb_axi_burst_reader;

  localparam int DEPTH = 32;

  logic        IP_CLK = 1'b0;
  logic        IP_ARESET_N = 1'b0;
  logic        start = 1'b0;
  logic [31:0] base_addr = '0;
  logic [31:0] len_bytes = '0;
  logic        busy, done, err;
  logic [31:0] M_ARADDR;
  logic        M_ARVALID;
  logic        M_ARREADY = 1'b0;
  logic [3:0]  M_ARLEN;
  logic [1:0]  M_ARSIZE, M_ARBURST;
  logic [63:0] M_RDATA = '0;
  logic        M_RVALID = 1'b0;
  logic        M_RREADY;
  logic [1:0]  M_RRESP = '0;
  logic        M_RLAST = 1'b0;
  logic [64:0] out_data;
  logic        out_ready = 1'b0;

  always #5 IP_CLK = ~IP_CLK;

  axi_burst_reader #(.FIFO_DEPTH(DEPTH), .BURST_BEATS(16)) dut (
    .IP_CLK(IP_CLK), .IP_ARESET_N(IP_ARESET_N), .start(start),
    .base_addr(base_addr), .len_bytes(len_bytes), .busy(busy), .done(done), .err(err),
    .M_ARADDR(M_ARADDR), .M_ARVALID(M_ARVALID), .M_ARREADY(M_ARREADY),
    .M_ARLEN(M_ARLEN), .M_ARSIZE(M_ARSIZE), .M_ARBURST(M_ARBURST),
    .M_RDATA(M_RDATA), .M_RVALID(M_RVALID), .M_RREADY(M_RREADY),
    .M_RRESP(M_RRESP), .M_RLAST(M_RLAST), .out_data(out_data), .out_ready(out_ready)
  );

  int tests_run = 0;
  int fails = 0;
  int cyc = 0;

  logic [31:0] exp_ar_q[$];
  logic [63:0] exp_beat_q[$];
  logic [31:0] burst_q[$];
  int          burst_cyc_q[$];

  // Stimulus knobs: ar_mode 0 always / 1 random / 2 never / 3 only first burst;
  // out_mode 0 always / 1 random / 2 never.
  int ar_mode = 0, out_mode = 0;
  bit r_gap = 0;
  int inj_rresp_burst = -1, inj_rresp_beat = -1;
  int inj_rlast_burst = -1, inj_rlast_beat = -1;
  logic [31:0] salt = 32'h1234_5678;

  int ar_count, pop_count, r_acc, max_occ, viol, pops_at_ar3;
  int done_cnt, done_cyc, last_pop_cyc, r_burst_idx;
  bit          r_active = 0;
  logic [31:0] r_addr;
  int          r_beat;

  function automatic logic [63:0] model_data(input logic [31:0] a);
    return {a ^ salt, ~a};
  endfunction

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    tests_run++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic clear_stats();
    ar_count = 0; pop_count = 0; r_acc = 0; max_occ = 0; viol = 0;
    pops_at_ar3 = -1; done_cnt = 0; done_cyc = -1; last_pop_cyc = -1; r_burst_idx = 0;
    inj_rresp_burst = -1; inj_rresp_beat = -1; inj_rlast_burst = -1; inj_rlast_beat = -1;
  endtask

  // Reference model: a job is a list of 128-byte bursts; each beat carries
  // the memory word at its byte address.
  task automatic do_start(input logic [31:0] b, input logic [31:0] l);
    logic [31:0] a0;
    int nb;
    a0 = {b[31:7], 7'b0};
    nb = int'(l >> 7);
    for (int bi = 0; bi < nb; bi++) begin
      exp_ar_q.push_back(a0 + 32'(128 * bi));
      for (int i = 0; i < 16; i++) exp_beat_q.push_back(model_data(a0 + 32'(128 * bi + 8 * i)));
    end
    @(negedge IP_CLK);
    start = 1'b1; base_addr = b; len_bytes = l;
    @(negedge IP_CLK);
    start = 1'b0;
  endtask

  task automatic finish_test(input string name, input logic exp_err, input bit timing);
    int n = 0;
    while (done_cnt == 0 && n < 5000) begin
      @(negedge IP_CLK);
      n++;
    end
    if (done_cnt == 0) begin
      tests_run++; fails++;
      $display("FAIL %s_done_timeout: actual=no done required=done", name);
    end
    repeat (3) @(negedge IP_CLK);
    check({name, "_done_count"}, done_cnt, 1);
    check({name, "_beats_left"}, exp_beat_q.size(), 0);
    check({name, "_ars_left"}, exp_ar_q.size(), 0);
    check({name, "_err"}, err, exp_err);
    check({name, "_busy"}, busy, 0);
    check({name, "_occupancy_ok"}, max_occ <= DEPTH, 1);
    check({name, "_protocol_viol"}, viol, 0);
    if (timing) check({name, "_done_after_last_pop"}, done_cyc, last_pop_cyc + 1);
  endtask

  initial begin
    forever begin
      @(posedge IP_CLK);
      cyc++;
      if ((r_acc - pop_count) > max_occ) max_occ = r_acc - pop_count;
    end
  end

  // AR responder and address scoreboard
  initial begin
    logic rdy;
    bit prev_wait;
    logic [31:0] prev_addr;
    prev_wait = 0; prev_addr = '0;
    forever begin
      @(negedge IP_CLK);
      if (!IP_ARESET_N) begin
        M_ARREADY = 1'b0; prev_wait = 0;
      end else begin
        case (ar_mode)
          0: rdy = 1'b1;
          1: rdy = 1'($urandom_range(0, 1));
          3: rdy = (ar_count < 1);
          default: rdy = 1'b0;
        endcase
        M_ARREADY = rdy;
        if (prev_wait && (!M_ARVALID || M_ARADDR != prev_addr)) viol++;
        if (M_ARVALID && rdy) begin
          ar_count++;
          if (ar_count == 3) pops_at_ar3 = pop_count;
          if (exp_ar_q.size() == 0) begin
            tests_run++; fails++;
            $display("FAIL ar_unexpected: actual=%0h required=none", M_ARADDR);
          end else begin
            check("ar_addr", M_ARADDR, exp_ar_q.pop_front());
          end
          check("ar_attr", {M_ARLEN, M_ARSIZE, M_ARBURST}, {4'hF, 2'b11, 2'b01});
          burst_q.push_back(M_ARADDR);
          burst_cyc_q.push_back(cyc);
        end
        prev_wait = M_ARVALID && !rdy;
        prev_addr = M_ARADDR;
      end
    end
  end

  // R responder: 16 beats per accepted burst, optional gaps and fault injection
  initial begin
    forever begin
      @(negedge IP_CLK);
      if (!IP_ARESET_N) begin
        r_active = 0; M_RVALID = 1'b0; M_RLAST = 1'b0; M_RRESP = 2'b00;
      end else begin
        if (!r_active && burst_q.size() > 0 && burst_cyc_q[0] < cyc) begin
          r_addr = burst_q.pop_front();
          void'(burst_cyc_q.pop_front());
          r_beat = 0; r_active = 1; r_burst_idx++;
        end
        if (r_active && (!r_gap || $urandom_range(0, 3) != 0)) begin
          M_RVALID = 1'b1;
          M_RDATA  = model_data(r_addr + 32'(8 * r_beat));
          M_RRESP  = (r_burst_idx == inj_rresp_burst && r_beat == inj_rresp_beat) ? 2'b10 : 2'b00;
          M_RLAST  = (r_beat == 15) || (r_burst_idx == inj_rlast_burst && r_beat == inj_rlast_beat);
          if (M_RREADY) begin
            r_acc++; r_beat++;
            if (r_beat == 16) r_active = 0;
          end
        end else begin
          M_RVALID = 1'b0; M_RLAST = 1'b0; M_RRESP = 2'b00;
        end
      end
    end
  end

  // Output monitor: pops the expected beat queue on every accepted beat
  initial begin
    logic rdy;
    forever begin
      @(negedge IP_CLK);
      if (!IP_ARESET_N) begin
        out_ready = 1'b0;
      end else begin
        case (out_mode)
          0: rdy = 1'b1;
          1: rdy = 1'($urandom_range(0, 1));
          default: rdy = 1'b0;
        endcase
        out_ready = rdy;
        if (done) begin
          done_cnt++; done_cyc = cyc;
        end
        if (out_data[64] && rdy) begin
          pop_count++;
          if (exp_beat_q.size() == 0) begin
            tests_run++; fails++;
            $display("FAIL beat_unexpected: actual=%0h required=none", out_data[63:0]);
          end else begin
            check("beat_data", out_data[63:0], exp_beat_q.pop_front());
            if (exp_beat_q.size() == 0) last_pop_cyc = cyc;
          end
        end
      end
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    clear_stats();
    repeat (3) @(negedge IP_CLK);
    check("rst_arvalid", M_ARVALID, 0);
    check("rst_araddr", M_ARADDR, 0);
    check("rst_rready", M_RREADY, 0);
    check("rst_out_data", out_data, 0);
    check("rst_status", {busy, done, err}, 3'b000);
    IP_ARESET_N = 1'b1;
    repeat (2) @(negedge IP_CLK);

    // Basic 4-burst transfer, everything always ready
    clear_stats(); ar_mode = 0; out_mode = 0; r_gap = 0;
    do_start(32'h0000_1000, 32'h0000_0200);
    check("t1_first_arvalid", M_ARVALID, 1);
    check("t1_busy", busy, 1);
    finish_test("t1", 1'b0, 1);
    check("t1_ar_count", ar_count, 4);

    // Zero length: done next cycle, no request
    clear_stats();
    do_start(32'h0000_2000, 32'h0000_0040);
    check("t2_done_next", done, 1);
    check("t2_busy", busy, 0);
    repeat (5) @(negedge IP_CLK);
    check("t2_ar_count", ar_count, 0);
    check("t2_done_count", done_cnt, 1);

    // Stalled consumer: credit allows exactly two bursts
    clear_stats(); out_mode = 2; salt = $urandom;
    do_start(32'h0001_0000, 32'h0000_0400);
    repeat (100) @(negedge IP_CLK);
    check("t3_ar_count_stalled", ar_count, 2);
    check("t3_head_valid", out_data[64], 1);
    out_mode = 1;
    finish_test("t3", 1'b0, 1);
    check("t3_ar3_after_16_pops", pops_at_ar3 >= 16, 1);

    // RRESP error on beat 5 of burst 2
    clear_stats(); ar_mode = 1; out_mode = 1; r_gap = 1; salt = $urandom;
    inj_rresp_burst = 2; inj_rresp_beat = 4;
    do_start(32'h0002_0000, 32'h0000_0300);
    finish_test("t4", 1'b1, 1);

    // Next start clears err
    clear_stats(); salt = $urandom;
    do_start(32'h0003_0000, 32'h0000_0100);
    check("t4b_err_cleared", err, 0);
    finish_test("t4b", 1'b0, 1);

    // Early RLAST on beat 8 of burst 1
    clear_stats(); salt = $urandom;
    inj_rlast_burst = 1; inj_rlast_beat = 7;
    do_start(32'h0004_0000, 32'h0000_0200);
    finish_test("t5", 1'b1, 1);

    // Randomized transfers, unaligned inputs
    for (int k = 0; k < 4; k++) begin
      clear_stats(); salt = $urandom;
      ar_mode = 1; out_mode = 1; r_gap = 1;
      do_start($urandom, (32'($urandom_range(1, 6)) << 7) | 32'($urandom_range(0, 127)));
      finish_test("trand", 1'b0, 1);
    end

    // Asynchronous reset mid-run with ARVALID pending and data buffered
    clear_stats(); ar_mode = 3; out_mode = 2; r_gap = 0; salt = $urandom;
    do_start(32'h0008_0000, 32'h0000_0200);
    repeat (30) @(negedge IP_CLK);
    check("t6_arvalid_before", M_ARVALID, 1);
    check("t6_head_before", out_data[64], 1);
    #2 IP_ARESET_N = 1'b0;
    #1;
    check("t6_arvalid_rst", M_ARVALID, 0);
    check("t6_busy_rst", busy, 0);
    check("t6_head_rst", out_data[64], 0);
    exp_ar_q.delete(); exp_beat_q.delete(); burst_q.delete(); burst_cyc_q.delete();
    repeat (2) @(negedge IP_CLK);
    IP_ARESET_N = 1'b1;
    @(negedge IP_CLK);
    clear_stats(); ar_mode = 0; out_mode = 1; salt = $urandom;
    do_start(32'h0009_0000, 32'h0000_0180);
    finish_test("t6_after", 1'b0, 1);

    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
